vic_bank_mapper: RTL and testbench
==================================

// Module: vic_bank_mapper
// PURPOSE
//  Parametrised cartridge bank mapper: NUM_BLKS CPU-visible memory blocks, each with a 2-bit mode
//  and a BANK_WIDTH-bit bank register, decoded into flash/RAM chip enables and a banked high address.
//  Register file sits behind the I/O decode; includes a self-reset sequencer that pulses system reset.
// PARAMETERS
//  NUM_BLKS     5        blocks mapped, 1..8; index 0 = lowest-priority-number (RAM area), 4 = BLK5
//  BANK_WIDTH   10       bank output width, 9..16
//  RESET_PULSE  2        cycles the system reset drive is held after a soft reset, 1..15
//  DEFAULT_MODE 16'h0100 reset value of packed modes {blk7..blk0}, 2 bits each (blk4 = ROM)
// PORTS
//  clock        in   1          system clock; all state on rising edge
//  reset        in   1          synchronous, active-low
//  reg_cs       in   1          register window select, active high
//  r_w          in   1          1 = read, 0 = write
//  reg_addr     in   5          register index
//  wdata        in   8          write data
//  rdata        out  8          read data
//  rdata_oe     out  1          drive rdata onto bus
//  blk_sel_n    in   NUM_BLKS   block strobes, active low
//  bank         out  BANK_WIDTH banked high address for selected block
//  flash_ce_n   out  1          flash enable, active low
//  ram_ce_n     out  1          RAM enable, active low
//  we_n / oe_n  out  1 / 1      memory write / output enable, active low
//  sys_reset_o  out  1          1 = pull system reset low (open-drain at top level)
//  busy         out  1          soft-reset sequence in progress
// BEHAVIOUR
//  Map: 0x00 CTRL (b7 W soft reset, reads 0; b6 LOCK, see CONFIGURATION; others read 0);
//   0x01 MODE_LO blk3..0; 0x02 MODE_HI blk7..4; 0x08+i BANK_LO[i] = bank[7:0];
//   0x10+i BANK_HI[i] = bank[BANK_WIDTH-1:8], unused bits read 0. i >= NUM_BLKS and other addrs: write ignored, read 0x00.
//  Write: reg_cs & !r_w & state==IDLE -> register updated on that clock edge; read combinational,
//   rdata_oe = reg_cs & r_w & state==IDLE; rdata = 0x00 when !rdata_oe.
//  Reset (reset==0): modes = DEFAULT_MODE, banks = 0, LOCK = 0, state = IDLE, sys_reset_o = 0,
//   busy = 0; outputs then follow decode below (no block selected -> all enables 1, bank = 0).
//  Modes: 00 absent; 01 ROM (flash_ce_n=0, we_n=1); 10 RAM read-only (ram_ce_n=0, we_n=1);
//   11 RAM R/W (ram_ce_n=0, we_n = r_w). oe_n = !(r_w & any CE active).
//  Select: lowest-index asserted blk_sel_n wins when several are low; none low -> enables 1, bank 0.
//   bank = {BANK_HI[w], BANK_LO[w]} of winner w; decode is combinational, zero latency.
//  Soft-reset FSM: IDLE -(CTRL write, b7=1)-> ARM (1 cycle) -> PULSE (RESET_PULSE cycles) -> IDLE.
//   ARM and PULSE: busy=1, all registers forced to reset values, register writes ignored,
//   rdata_oe=0; PULSE: sys_reset_o=1. CTRL write with b7=1 also applies no other bits.
//  reset low in any state -> IDLE next edge, sys_reset_o=0 same edge. Pulse counter never wraps.
// CONFIGURATION
//  VICMIDI_REG_LOCK_EN defined: CTRL b6 write 1 sets LOCK (sticky); while LOCK=1, MODE/BANK writes
//   ignored, CTRL b7 soft reset still honoured; LOCK cleared only by reset or soft-reset sequence;
//   CTRL reads {0, LOCK, 6'b0}.
//  Not defined: b6 ignored on write, reads 0; MODE/BANK always writable in IDLE.
// TESTING
//  Reset, no writes: blk_sel_n=5'b01111, r_w=1 -> flash_ce_n=0, ram_ce_n=1, oe_n=0, bank=0.
//  Write BANK_LO[1]=0xA5, BANK_HI[1]=0x02, MODE_LO=0x0C; blk_sel_n=5'b11101, r_w=0 -> ram_ce_n=0,
//   we_n=0, bank=10'h2A5; readback 0x09 = 0xA5, 0x11 = 0x02.
//  MODE_LO=0x08 (blk1 RAM R/O), write cycle to blk1 -> ram_ce_n=0, we_n=1.
//  blk_sel_n=5'b11100 with blk0/blk1 distinct banks -> bank and enables from blk0.
//  Write CTRL=0x80 -> busy=1 next cycle, sys_reset_o=1 for exactly RESET_PULSE (2) cycles
//   after 1 ARM cycle, then MODE read 0x00/0x01 defaults; write during PULSE has no effect.
//  VICMIDI_REG_LOCK_EN: CTRL=0x40, then BANK_LO[0]=0x33 -> reads 0x00; CTRL=0x80 -> LOCK read 0.

Source files
------------

// File: rtl/vic_bank_mapper.sv
// Cartridge bank mapper: register file, combinational block decode and soft-reset sequencer.
// Define VICMIDI_REG_LOCK_EN to build in the sticky register-lock bit (CTRL b6).
module vic_bank_mapper #(
  parameter int          NUM_BLKS     = 5,
  parameter int          BANK_WIDTH   = 10,
  parameter int          RESET_PULSE  = 2,
  parameter logic [15:0] DEFAULT_MODE = 16'h0100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reg_cs,
  input  logic                  r_w,
  input  logic [4:0]            reg_addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic                  rdata_oe,
  input  logic [NUM_BLKS-1:0]   blk_sel_n,
  output logic [BANK_WIDTH-1:0] bank,
  output logic                  flash_ce_n,
  output logic                  ram_ce_n,
  output logic                  we_n,
  output logic                  oe_n,
  output logic                  sys_reset_o,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_PULSE} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_pulse_cnt, w_pulse_cnt_nxt;
  logic [15:0]           r_modes;
  logic [BANK_WIDTH-1:0] r_bank [NUM_BLKS];

  logic                  w_idle, w_wr, w_soft, w_lock, w_clear;
  logic [7:0]            w_rdata;
  logic [15:0]           w_bank_ext;
  logic [1:0]            w_mode;
  logic [BANK_WIDTH-1:0] w_bank;

  assign w_idle  = (r_state == S_IDLE);
  assign w_wr    = reg_cs & ~r_w & w_idle;
  assign w_soft  = w_wr & (reg_addr == 5'h00) & wdata[7];
  // A soft-reset request already loads defaults, so ARM/PULSE never expose stale mappings.
  assign w_clear = ~reset | ~w_idle | w_soft;

  // NOTE: combinational processes use blocking '=' and assign every output a default first,
  // so no latch is inferred; clocked processes use '<=' only.
  always_comb begin
    w_state_nxt     = r_state;
    w_pulse_cnt_nxt = r_pulse_cnt;
    case (r_state)
      S_IDLE:  if (w_soft) w_state_nxt = S_ARM;
      S_ARM: begin
        w_state_nxt     = S_PULSE;
        w_pulse_cnt_nxt = '0;
      end
      S_PULSE: begin
        if (r_pulse_cnt == 4'(RESET_PULSE - 1)) w_state_nxt = S_IDLE;
        else                                     w_pulse_cnt_nxt = r_pulse_cnt + 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pulse_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
    end
  end

  assign busy        = ~w_idle;
  assign sys_reset_o = (r_state == S_PULSE);

  // NOTE: the bank array is a handful of flops, not a RAM macro, so it is reset like any register.
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_modes <= DEFAULT_MODE;
      for (int i = 0; i < NUM_BLKS; i++) r_bank[i] <= '0;
    end else if (w_wr && !w_lock) begin
      if (reg_addr == 5'h01) r_modes[7:0]  <= wdata;
      if (reg_addr == 5'h02) r_modes[15:8] <= wdata;
      for (int i = 0; i < NUM_BLKS; i++) begin
        if (reg_addr == 5'(8 + i))  r_bank[i][7:0]            <= wdata;
        if (reg_addr == 5'(16 + i)) r_bank[i][BANK_WIDTH-1:8] <= wdata[BANK_WIDTH-9:0];
      end
    end
  end

`ifdef VICMIDI_REG_LOCK_EN
  logic r_lock;

  always_ff @(posedge clock) begin
    if (w_clear)                                         r_lock <= 1'b0;
    else if (w_wr && (reg_addr == 5'h00) && wdata[6])    r_lock <= 1'b1;
  end

  assign w_lock = r_lock;
`else
  assign w_lock = 1'b0;
`endif

  always_comb begin
    w_rdata    = 8'h00;
    w_bank_ext = '0;
    if (reg_addr == 5'h00) w_rdata = {1'b0, w_lock, 6'b0};
    if (reg_addr == 5'h01) w_rdata = r_modes[7:0];
    if (reg_addr == 5'h02) w_rdata = r_modes[15:8];
    for (int i = 0; i < NUM_BLKS; i++) begin
      if (reg_addr == 5'(8 + i)) w_rdata = r_bank[i][7:0];
      if (reg_addr == 5'(16 + i)) begin
        w_bank_ext = 16'(r_bank[i]);
        w_rdata    = w_bank_ext[15:8];
      end
    end
  end

  assign rdata_oe = reg_cs & r_w & w_idle;
  assign rdata    = rdata_oe ? w_rdata : 8'h00;

  // Scanning from the top down lets the lowest-index strobe overwrite and win.
  always_comb begin
    w_mode = 2'b00;
    w_bank = '0;
    for (int i = NUM_BLKS - 1; i >= 0; i--) begin
      if (!blk_sel_n[i]) begin
        w_mode = r_modes[2*i +: 2];
        w_bank = r_bank[i];
      end
    end
  end

  assign flash_ce_n = ~(w_mode == 2'b01);
  assign ram_ce_n   = ~w_mode[1];
  assign we_n       = (w_mode == 2'b11) ? r_w : 1'b1;
  assign oe_n       = ~(r_w & (~flash_ce_n | ~ram_ce_n));
  assign bank       = w_bank;

endmodule

// File: tb/tb_vic_bank_mapper.sv
// Self-checking bench for vic_bank_mapper: expected values queued with stimulus, popped on sampling.
module tb_vic_bank_mapper;

  localparam int NUM_BLKS    = 5;
  localparam int BANK_WIDTH  = 10;
  localparam int RESET_PULSE = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  reg_cs = 1'b0;
  logic                  r_w = 1'b1;
  logic [4:0]            reg_addr = '0;
  logic [7:0]            wdata = '0;
  logic [7:0]            rdata;
  logic                  rdata_oe;
  logic [NUM_BLKS-1:0]   blk_sel_n = '1;
  logic [BANK_WIDTH-1:0] bank;
  logic                  flash_ce_n, ram_ce_n, we_n, oe_n, sys_reset_o, busy;

  always #5 clock = ~clock;

  vic_bank_mapper #(
    .NUM_BLKS(NUM_BLKS), .BANK_WIDTH(BANK_WIDTH), .RESET_PULSE(RESET_PULSE),
    .DEFAULT_MODE(16'h0100)
  ) dut (
    .clock(clock), .reset(reset), .reg_cs(reg_cs), .r_w(r_w), .reg_addr(reg_addr),
    .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe), .blk_sel_n(blk_sel_n), .bank(bank),
    .flash_ce_n(flash_ce_n), .ram_ce_n(ram_ce_n), .we_n(we_n), .oe_n(oe_n),
    .sys_reset_o(sys_reset_o), .busy(busy)
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic sb_t mk(input string n, input logic [15:0] e);
    sb_t s;
    s.name = n;
    s.exp  = e;
    return s;
  endfunction

  function automatic logic [15:0] dec_exp(input logic f, input logic r, input logic w,
                                          input logic o, input logic [9:0] b);
    return {f, r, w, o, 2'b00, b};
  endfunction

  task automatic reg_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    reg_cs = 1'b1; r_w = 1'b0; reg_addr = a; wdata = d;
    @(negedge clock);
    reg_cs = 1'b0; r_w = 1'b1;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [15:0] obs);
    @(negedge clock);
    reg_cs = 1'b1; r_w = 1'b1; reg_addr = a;
    #1 obs = {7'b0, rdata_oe, rdata};
    reg_cs = 1'b0;
  endtask

  task automatic drive_sel(input logic [4:0] sel, input logic rw, output logic [15:0] obs);
    @(negedge clock);
    blk_sel_n = sel; r_w = rw;
    #1 obs = {flash_ce_n, ram_ce_n, we_n, oe_n, 2'b00, bank};
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    sb_t e;
    logic [4:0] ra [3] = '{5'h00, 5'h01, 5'h02};
    logic [7:0] rd [3] = '{8'h00, 8'h00, 8'h01};
    reset = 1'b0; blk_sel_n = '1; r_w = 1'b1;
    repeat (2) @(negedge clock);
    sb_q.push_back(mk("reset_status", 16'h0000));
    #1 obs = {14'b0, busy, sys_reset_o};
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    sb_q.push_back(mk("reset_idle_decode", dec_exp(1, 1, 1, 1, 10'h000)));
    obs = {flash_ce_n, ram_ce_n, we_n, oe_n, 2'b00, bank};
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    reset = 1'b1;
    sb_q.push_back(mk("reset_blk5_rom", dec_exp(0, 1, 1, 0, 10'h000)));
    drive_sel(5'b01111, 1'b1, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk($sformatf("reset_read_%02h", ra[i]), {8'h01, rd[i]}));
      reg_read(ra[i], obs);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_bank_ram();
    logic [15:0] obs;
    sb_t e;
    logic [4:0] ra [3] = '{5'h09, 5'h11, 5'h01};
    logic [7:0] rd [3] = '{8'hA5, 8'h02, 8'h0C};
    reg_write(5'h09, 8'hA5);
    reg_write(5'h11, 8'h02);
    reg_write(5'h01, 8'h0C);
    sb_q.push_back(mk("rw_ram_write", dec_exp(1, 0, 0, 1, 10'h2A5)));
    drive_sel(5'b11101, 1'b0, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    sb_q.push_back(mk("rw_ram_read", dec_exp(1, 0, 1, 0, 10'h2A5)));
    drive_sel(5'b11101, 1'b1, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk($sformatf("bank_read_%02h", ra[i]), {8'h01, rd[i]}));
      reg_read(ra[i], obs);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_ram_ro();
    logic [15:0] obs;
    sb_t e;
    reg_write(5'h01, 8'h08);
    sb_q.push_back(mk("ro_ram_write_blocked", dec_exp(1, 0, 1, 1, 10'h2A5)));
    drive_sel(5'b11101, 1'b0, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
  endtask

  task automatic test_priority();
    logic [15:0] obs;
    sb_t e;
    logic [4:0]  sel [4] = '{5'b11100, 5'b11101, 5'b11111, 5'b01111};
    logic        rw  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] ex  [4];
    logic [4:0]  ra  [3] = '{5'h10, 5'h0D, 5'h18};
    logic [7:0]  rd  [3] = '{8'h03, 8'h00, 8'h00};
    ex[0] = dec_exp(0, 1, 1, 0, 10'h33C);
    ex[1] = dec_exp(1, 0, 0, 1, 10'h2A5);
    ex[2] = dec_exp(1, 1, 1, 1, 10'h000);
    ex[3] = dec_exp(0, 1, 1, 0, 10'h000);
    reg_write(5'h08, 8'h3C);
    reg_write(5'h10, 8'hFF);
    reg_write(5'h01, 8'h0D);
    reg_write(5'h0D, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mk($sformatf("prio_sel_%05b", sel[i]), ex[i]));
      drive_sel(sel[i], rw[i], obs);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk($sformatf("edge_read_%02h", ra[i]), {8'h01, rd[i]}));
      reg_read(ra[i], obs);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    end
    sb_q.push_back(mk("rdata_idle_zero", 16'h0000));
    @(negedge clock);
    reg_cs = 1'b0; r_w = 1'b1; reg_addr = 5'h09;
    #1 obs = {7'b0, rdata_oe, rdata};
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] obs;
    sb_t e;
    logic [4:0] ra [3] = '{5'h08, 5'h09, 5'h0C};
    logic [7:0] rd [3] = '{8'h11, 8'h22, 8'h55};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      reg_cs = 1'b1; r_w = 1'b0; reg_addr = ra[i]; wdata = rd[i];
    end
    @(negedge clock);
    reg_cs = 1'b0; r_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(mk($sformatf("b2b_read_%02h", ra[i]), {8'h01, rd[i]}));
      reg_read(ra[i], obs);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_soft_reset();
    logic [15:0] obs;
    sb_t e;
    int cnt = 0;
    int first = -1;
    logic [4:0] ra [4] = '{5'h01, 5'h02, 5'h09, 5'h10};
    logic [7:0] rd [4] = '{8'h00, 8'h01, 8'h00, 8'h00};
    @(negedge clock);
    reg_cs = 1'b1; r_w = 1'b0; reg_addr = 5'h00; wdata = 8'h80;
    @(negedge clock);
    r_w = 1'b1;
    sb_q.push_back(mk("arm_status", 16'h0002));
    #1 obs = {13'b0, rdata_oe, busy, sys_reset_o};
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    reg_cs = 1'b0;
    sb_q.push_back(mk("pulse_cycles", 16'(RESET_PULSE)));
    sb_q.push_back(mk("pulse_first_cycle", 16'h0000));
    sb_q.push_back(mk("post_pulse_status", 16'h0000));
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 0) begin reg_cs = 1'b1; r_w = 1'b0; reg_addr = 5'h09; wdata = 8'h77; end
      else begin reg_cs = 1'b0; r_w = 1'b1; end
      #1;
      if (sys_reset_o) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    obs = 16'(cnt);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    obs = 16'(first);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    obs = {14'b0, busy, sys_reset_o};
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mk($sformatf("soft_read_%02h", ra[i]), {8'h01, rd[i]}));
      reg_read(ra[i], obs);
      e = sb_q.pop_front(); n_checks++;
      if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    end
    sb_q.push_back(mk("soft_decode_absent", dec_exp(1, 1, 1, 1, 10'h000)));
    drive_sel(5'b11101, 1'b0, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] obs;
    sb_t e;
    reg_write(5'h00, 8'h80);
    @(negedge clock);
    sb_q.push_back(mk("abort_in_pulse", 16'h0003));
    #1 obs = {14'b0, busy, sys_reset_o};
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    reset = 1'b0;
    @(negedge clock);
    sb_q.push_back(mk("abort_after_reset", 16'h0000));
    #1 obs = {14'b0, busy, sys_reset_o};
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    reset = 1'b1;
    reg_write(5'h08, 8'h55);
    sb_q.push_back(mk("abort_write_ok", 16'h0155));
    reg_read(5'h08, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
  endtask

  task automatic test_lock();
    logic [15:0] obs;
    sb_t e;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    reg_write(5'h00, 8'h40);
`ifdef VICMIDI_REG_LOCK_EN
    sb_q.push_back(mk("lock_ctrl_read", 16'h0140));
    sb_q.push_back(mk("lock_bank_blocked", 16'h0100));
    sb_q.push_back(mk("lock_mode_blocked", 16'h0100));
    sb_q.push_back(mk("lock_cleared", 16'h0100));
    sb_q.push_back(mk("lock_bank_after", 16'h0133));
    reg_read(5'h00, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    reg_write(5'h08, 8'h33);
    reg_read(5'h08, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    reg_write(5'h01, 8'hFF);
    reg_read(5'h01, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
    reg_write(5'h00, 8'h80);
    repeat (RESET_PULSE + 3) @(negedge clock);
    reg_read(5'h00, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
`else
    sb_q.push_back(mk("nolock_ctrl_read", 16'h0100));
    sb_q.push_back(mk("nolock_bank_write", 16'h0133));
    reg_read(5'h00, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
`endif
    reg_write(5'h08, 8'h33);
    reg_read(5'h08, obs);
    e = sb_q.pop_front(); n_checks++;
    if (obs !== e.exp) begin n_errors++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bank_ram();
    test_ram_ro();
    test_priority();
    test_back_to_back();
    test_soft_reset();
    test_reset_abort();
    test_lock();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
